// File: rtl/pcie_msg_transmitter.sv
// Sends one message as an AXI write burst: the header rides in the low half of beat 0,
// and every beat payload is fetched from a 1-cycle-latency SRAM.
module pcie_msg_transmitter #(
  parameter int SRAM_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_start,
  input  logic [127:0]       tx_header,
  input  logic [11:0]        tx_len,
  input  logic [SRAM_AW-1:0] tx_sram_base,
  input  logic [63:0]        tx_axi_addr,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               tx_err,
  output logic               sram_ren,
  output logic [SRAM_AW-1:0] sram_raddr,
  input  logic [255:0]       sram_rdata,
  output logic               axi_awvalid,
  output logic [63:0]        axi_awaddr,
  output logic [11:0]        axi_awlen,
  output logic [2:0]         axi_awsize,
  output logic [1:0]         axi_awburst,
  input  logic               axi_awready,
  output logic               axi_wvalid,
  output logic [255:0]       axi_wdata,
  output logic [31:0]        axi_wstrb,
  output logic               axi_wlast,
  input  logic               axi_wready,
  input  logic               axi_bvalid,
  input  logic [1:0]         axi_bresp,
  output logic               axi_bready,
  output logic [2:0]         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a raised valid and its payload hold until that edge, and ready never gates valid.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AW    = 3'd1,
    RD    = 3'd2,
    CAP   = 3'd3,
    WDATA = 3'd4,
    BRESP = 3'd5
  } state_t;

  state_t             state, state_next;
  logic [127:0]       hdr_q;
  logic [11:0]        len_q;
  logic [11:0]        beat_q;
  logic [SRAM_AW-1:0] base_q;
  logic               start_ok, aw_hs, w_hs, b_hs;

  assign start_ok  = tx_start && (tx_len != 12'd0);
  assign aw_hs     = axi_awvalid && axi_awready;
  assign w_hs      = axi_wvalid && axi_wready;
  assign b_hs      = axi_bready && axi_bvalid;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = AW;
      AW:      if (aw_hs) state_next = RD;
      RD:      state_next = CAP;
      CAP:     state_next = WDATA;
      WDATA:   if (w_hs) state_next = axi_wlast ? BRESP : RD;
      BRESP:   if (b_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      base_q      <= '0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      sram_ren    <= 1'b0;
      sram_raddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      axi_awsize  <= '0;
      axi_awburst <= '0;
      axi_wvalid  <= 1'b0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_wlast   <= 1'b0;
      axi_bready  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: if (start_ok) begin
          hdr_q       <= tx_header;
          len_q       <= tx_len;
          base_q      <= tx_sram_base;
          beat_q      <= '0;
          tx_err      <= 1'b0;
          tx_busy     <= 1'b1;
          axi_awvalid <= 1'b1;
          axi_awaddr  <= tx_axi_addr;
          axi_awlen   <= tx_len - 12'd1;
          axi_awsize  <= 3'b101;
          axi_awburst <= 2'b01;
        end
        AW: if (aw_hs) begin
          axi_awvalid <= 1'b0;
          sram_ren    <= 1'b1;
          sram_raddr  <= base_q;
        end
        RD: sram_ren <= 1'b0;
        CAP: begin
          // SRAM data for the beat requested in RD is on sram_rdata now.
          axi_wvalid <= 1'b1;
          axi_wstrb  <= 32'hFFFF_FFFF;
          axi_wlast  <= (beat_q == len_q - 12'd1);
          axi_wdata  <= (beat_q == 12'd0) ? {sram_rdata[255:128], hdr_q} : sram_rdata;
        end
        WDATA: if (w_hs) begin
          axi_wvalid <= 1'b0;
          axi_wstrb  <= '0;
          if (axi_wlast) begin
            axi_wlast  <= 1'b0;
            axi_bready <= 1'b1;
          end else begin
            beat_q     <= beat_q + 12'd1;
            sram_raddr <= sram_raddr + SRAM_AW'(1);
            sram_ren   <= 1'b1;
          end
        end
        BRESP: if (b_hs) begin
          axi_bready <= 1'b0;
          tx_done    <= 1'b1;
          tx_err     <= (axi_bresp != 2'b00);
          tx_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
